// File: rtl/bemicro_cv_nios_cpu_oci_dct_capture_pkg.sv
//============================================================================
// Module : bemicro_cv_nios_cpu_oci_dct_pkg
// Brief  : Shared types and default constants for the OCI DCT capture buffer.
// Rev    : 1.0
//============================================================================
`default_nettype none

package bemicro_cv_nios_cpu_oci_dct_pkg;

  localparam int c_dct_w = 30;
  localparam int c_cnt_w = 4;
  localparam int c_depth = 16;
  localparam int c_ovf_w = 8;
  localparam int c_ts_w  = 16;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_ENDED   = 2'd2
  } dct_state_e;

  // Entry layout at the default widths; the FIFO stores the same field order.
  typedef struct packed {
    logic [c_ts_w-1:0]  ts;
    logic [c_cnt_w-1:0] count;
    logic [c_dct_w-1:0] buffer;
  } dct_entry_t;

endpackage

`default_nettype wire

// File: rtl/bemicro_cv_nios_cpu_oci_dct_capture_if.sv
//============================================================================
// Module : bemicro_cv_nios_cpu_oci_dct_capture_if
// Brief  : Frame input, reader output and status bundle of the DCT capture.
// Rev    : 1.0
//============================================================================
`default_nettype none

interface bemicro_cv_nios_cpu_oci_dct_capture_if #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int OVF_W = 8,
  parameter int TS_W  = 16
);
  logic             dct_valid;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             test_ending;
  logic             out_valid;
  logic             out_ready;
  logic [DCT_W-1:0] out_buffer;
  logic [CNT_W-1:0] out_count;
  logic [TS_W-1:0]  out_ts;
  logic             overflow;
  logic [OVF_W-1:0] ovf_count;
  logic             test_has_ended;

  modport master (
    output dct_valid, dct_buffer, dct_count, test_ending, out_ready,
    input  out_valid, out_buffer, out_count, out_ts, overflow, ovf_count, test_has_ended
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, test_ending, out_ready,
    output out_valid, out_buffer, out_count, out_ts, overflow, ovf_count, test_has_ended
  );
endinterface

`default_nettype wire

// File: rtl/bemicro_cv_nios_cpu_oci_dct_capture_fifo.sv
//============================================================================
// Module : bemicro_cv_nios_cpu_oci_dct_fifo
// Brief  : Generic first-word-fall-through synchronous FIFO, power-of-two depth.
// Rev    : 1.0
//============================================================================
`default_nettype none

module bemicro_cv_nios_cpu_oci_dct_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_wr_en;
  logic               w_rd_en;

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  // Head reads as zero while empty so the uninitialised RAM never shows.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

endmodule

`default_nettype wire

// File: rtl/bemicro_cv_nios_cpu_oci_dct_capture.sv
//============================================================================
// Module : bemicro_cv_nios_cpu_oci_dct_capture
// Brief  : Captures OCI DCT frames into a FWFT FIFO, counts drops, and runs
//          the drain/ended handshake. Optional: OCI_DCT_TIMESTAMP_EN.
// Rev    : 1.0
//============================================================================
`default_nettype none

module bemicro_cv_nios_cpu_oci_dct_capture
  import bemicro_cv_nios_cpu_oci_dct_pkg::*;
#(
  parameter int DCT_W = c_dct_w,
  parameter int CNT_W = c_cnt_w,
  parameter int DEPTH = c_depth,
  parameter int OVF_W = c_ovf_w,
  parameter int TS_W  = c_ts_w
) (
  input  logic clk,
  input  logic reset,
  bemicro_cv_nios_cpu_oci_dct_capture_if.slave bus
);
`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int c_entry_w = TS_W + CNT_W + DCT_W;
`else
  localparam int c_entry_w = CNT_W + DCT_W;
`endif
  localparam int c_lvl_w = $clog2(DEPTH) + 1;
  localparam logic [c_lvl_w-1:0] c_lvl_one = {{(c_lvl_w-1){1'b0}}, 1'b1};
  localparam logic [OVF_W-1:0]   c_ovf_one = {{(OVF_W-1){1'b0}}, 1'b1};

  dct_state_e           r_state;
  logic                 r_overflow;
  logic [OVF_W-1:0]     r_ovf_count;
  logic                 r_has_ended;

  logic                 w_full;
  logic                 w_empty;
  logic [c_lvl_w-1:0]   w_level;
  logic                 w_pop;
  logic                 w_frame;
  logic                 w_push;
  logic                 w_drop;
  logic [c_entry_w-1:0] w_wdata;
  logic [c_entry_w-1:0] w_rdata;

  assign w_pop   = !w_empty && bus.out_ready;
  assign w_frame = (r_state == ST_CAPTURE) && bus.dct_valid && (bus.dct_count != '0);
  assign w_push  = w_frame && (!w_full || w_pop);
  assign w_drop  = w_frame && w_full && !w_pop;

  bemicro_cv_nios_cpu_oci_dct_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_CAPTURE;
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
      r_has_ended <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + c_ovf_one;
      end
      case (r_state)
        ST_CAPTURE: if (bus.test_ending) r_state <= ST_DRAIN;
        // Nothing is pushed in DRAIN, so a pop of the last entry empties it now.
        ST_DRAIN: if (w_empty || (w_pop && w_level == c_lvl_one)) begin
          r_state     <= ST_ENDED;
          r_has_ended <= 1'b1;
        end
        ST_ENDED: r_state <= ST_ENDED;
        default:  r_state <= ST_CAPTURE;
      endcase
    end
  end

`ifdef OCI_DCT_TIMESTAMP_EN
  localparam logic [TS_W-1:0] c_ts_one = {{(TS_W-1){1'b0}}, 1'b1};
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + c_ts_one;
  end

  assign w_wdata    = {r_ts, bus.dct_count, bus.dct_buffer};
  assign bus.out_ts = w_rdata[c_entry_w-1 -: TS_W];
`else
  assign w_wdata    = {bus.dct_count, bus.dct_buffer};
  assign bus.out_ts = {TS_W{1'b0}};
`endif

  assign bus.out_valid      = !w_empty;
  assign bus.out_buffer     = w_rdata[DCT_W-1:0];
  assign bus.out_count      = w_rdata[DCT_W +: CNT_W];
  assign bus.overflow       = r_overflow;
  assign bus.ovf_count      = r_ovf_count;
  assign bus.test_has_ended = r_has_ended;

endmodule

`default_nettype wire

// File: tb/tb_bemicro_cv_nios_cpu_oci_dct_capture.sv
//============================================================================
// Module : tb_bemicro_cv_nios_cpu_oci_dct_capture
// Brief  : Randomised self-checking bench with a queue-based reference model.
// Rev    : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bemicro_cv_nios_cpu_oci_dct_capture;
  import bemicro_cv_nios_cpu_oci_dct_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bemicro_cv_nios_cpu_oci_dct_capture_if #(.DCT_W(30), .CNT_W(4), .OVF_W(8), .TS_W(16)) bus();

  bemicro_cv_nios_cpu_oci_dct_capture #(
    .DCT_W(30), .CNT_W(4), .DEPTH(DEPTH), .OVF_W(8), .TS_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue of stored frames plus mode flags.
  dct_entry_t  mq[$];
  bit          m_drain;
  bit          m_ended;
  bit          m_ovf;
  int          m_ovfc;
  logic [15:0] m_ts;

  function automatic logic [50:0] exp_head();
    if (mq.size() == 0) return '0;
    return {1'b1, mq[0].buffer, mq[0].count, mq[0].ts};
  endfunction

  function automatic logic [50:0] got_head();
    if (bus.out_valid !== 1'b1) return {bus.out_valid, 50'd0};
    return {1'b1, bus.out_buffer, bus.out_count, bus.out_ts};
  endfunction

  task automatic cycle(input bit v, input logic [29:0] b, input logic [3:0] c,
                       input bit te, input bit rdy);
    bit pop, full, cap, push, drop;
    dct_entry_t e;
    bus.dct_valid = v; bus.dct_buffer = b; bus.dct_count = c;
    bus.test_ending = te; bus.out_ready = rdy;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    cap  = !m_drain && !m_ended;
    push = cap && v && (c != 0) && (!full || pop);
    drop = cap && v && (c != 0) && full && !pop;
    e.buffer = b;
    e.count  = c;
`ifdef OCI_DCT_TIMESTAMP_EN
    e.ts = m_ts;
`else
    e.ts = '0;
`endif
    @(posedge clk);
    m_ts = m_ts + 16'd1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    if (drop) begin
      m_ovf = 1'b1;
      if (m_ovfc < 255) m_ovfc++;
    end
    if (cap && te) m_drain = 1'b1;
    else if (m_drain && mq.size() == 0) begin
      m_drain = 1'b0;
      m_ended = 1'b1;
    end
    @(negedge clk);
    bus.dct_valid = 1'b0;
    bus.test_ending = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.dct_valid = 1'b0; bus.test_ending = 1'b0; bus.out_ready = 1'b0;
    bus.dct_buffer = '0; bus.dct_count = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_drain = 1'b0; m_ended = 1'b0; m_ovf = 1'b0; m_ovfc = 0; m_ts = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.out_valid, bus.out_buffer, bus.out_count, bus.out_ts,
         bus.overflow, bus.ovf_count, bus.test_has_ended} !== 62'd0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b buf=%h cnt=%h ts=%h ovf=%b ovfc=%0d end=%b required all zero",
               bus.out_valid, bus.out_buffer, bus.out_count, bus.out_ts,
               bus.overflow, bus.ovf_count, bus.test_has_ended);
    end
    do_reset();
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 30'(i), 4'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_buffer !== 30'(i) || bus.out_count !== 4'd3) begin
        n_fail++;
        $display("FAIL order_head%0d: got v=%b buf=%h cnt=%0d required v=1 buf=%h cnt=3",
                 i, bus.out_valid, bus.out_buffer, bus.out_count, 30'(i));
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
    end
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL order_empty: got out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 30'h3FFFFFFF, 4'd0, 1'b0, 1'b0);
      n_chk++;
      if ({bus.out_valid, bus.overflow, bus.ovf_count} !== 10'd0) begin
        n_fail++;
        $display("FAIL zero_count: got v=%b ovf=%b ovfc=%0d required 0 0 0",
                 bus.out_valid, bus.overflow, bus.ovf_count);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 300; i++)
      cycle(1'b1, 30'($urandom), 4'($urandom_range(1, 15)), 1'b0, 1'b0);
    n_chk++;
    if (bus.overflow !== 1'b1 || bus.ovf_count !== 8'd255) begin
      n_fail++;
      $display("FAIL overflow_sat: got ovf=%b ovfc=%0d required 1 255", bus.overflow, bus.ovf_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++;
      if (got_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL overflow_keep%0d: got %h required %h", i, got_head(), exp_head());
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
    end
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_drained: got out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 30'($urandom), 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 30'($urandom), 4'd5, 1'b0, 1'b1);
      n_chk++;
      if (got_head() !== exp_head() || bus.overflow !== 1'b0 || bus.ovf_count !== 8'd0) begin
        n_fail++;
        $display("FAIL full_pushpop%0d: got head=%h ovfc=%0d required head=%h ovfc=0",
                 i, got_head(), bus.ovf_count, exp_head());
      end
    end
    // A plain push must now drop, proving the FIFO stayed full.
    cycle(1'b1, 30'h1234, 4'd2, 1'b0, 1'b0);
    n_chk++;
    if (bus.ovf_count !== 8'd1 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_still_full: got ovf=%b ovfc=%0d required 1 1", bus.overflow, bus.ovf_count);
    end
  endtask

  task automatic test_min_latency();
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_chk++;
    if (bus.test_has_ended !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got test_has_ended=%b required 0", bus.test_has_ended);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    n_chk++;
    if (bus.test_has_ended !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_2cyc: got test_has_ended=%b required 1", bus.test_has_ended);
    end
  endtask

  task automatic test_drain();
    int rise_at;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 30'(16 + i), 4'd7, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    rise_at = -1;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 30'h2AAAAAAA, 4'd9, 1'b0, 1'b1);
      if (rise_at < 0 && bus.test_has_ended === 1'b1) rise_at = i;
      n_chk++;
      if (got_head() !== exp_head() ||
          {bus.overflow, bus.ovf_count, bus.test_has_ended} !== {m_ovf, 8'(m_ovfc), m_ended}) begin
        n_fail++;
        $display("FAIL drain_cycle%0d: got head=%h end=%b required head=%h end=%b",
                 i, got_head(), bus.test_has_ended, exp_head(), m_ended);
      end
    end
    // Pops happen in iterations 0..3, so the flag is first seen after iteration 3.
    n_chk++;
    if (rise_at != 3) begin
      n_fail++;
      $display("FAIL drain_rise: got rise at iteration %0d required 3", rise_at);
    end
    cycle(1'b1, 30'h55, 4'd1, 1'b1, 1'b0);
    n_chk++;
    if (bus.test_has_ended !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ended_sticky: got end=%b v=%b required 1 0", bus.test_has_ended, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 30'(100 + i), 4'd4, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.test_has_ended !== 1'b0 || bus.ovf_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b end=%b ovfc=%0d required 0 0 0",
               bus.out_valid, bus.test_has_ended, bus.ovf_count);
    end
    do_reset();
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 30'hABC, 4'd2, 1'b0, 1'b0);
    n_chk++;
    if (got_head() !== exp_head() || bus.out_buffer !== 30'hABC) begin
      n_fail++;
      $display("FAIL reset_capture: got %h required %h", got_head(), exp_head());
    end
`ifdef OCI_DCT_TIMESTAMP_EN
    n_chk++;
    if (bus.out_ts !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_ts: got out_ts=%0d required 1", bus.out_ts);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if (m_ended && $urandom_range(0, 9) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, 30'($urandom), 4'($urandom_range(0, 15)),
            $urandom_range(0, 80) == 0, $urandom_range(0, 2) == 0);
      n_chk++;
      if (got_head() !== exp_head() ||
          {bus.overflow, bus.ovf_count, bus.test_has_ended} !== {m_ovf, 8'(m_ovfc), m_ended}) begin
        n_fail++;
        $display("FAIL random%0d: got head=%h ovf=%b ovfc=%0d end=%b required head=%h ovf=%b ovfc=%0d end=%b",
                 i, got_head(), bus.overflow, bus.ovf_count, bus.test_has_ended,
                 exp_head(), m_ovf, m_ovfc, m_ended);
      end
    end
  endtask

  initial begin
    bus.dct_valid = 1'b0; bus.dct_buffer = '0; bus.dct_count = '0;
    bus.test_ending = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_order();
    test_zero_count();
    test_overflow();
    test_full_push_pop();
    test_min_latency();
    test_drain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bemicro_cv_nios_cpu_oci_dct_capture.md
# bemicro_cv_nios_cpu_oci_dct_capture

Parametrised capture buffer for Nios OCI debug-capture-trace (DCT) words. It is the synthesisable successor of the OCI test-bench DCT monitor. It accepts DCT frames (buffer plus slot count) from the OCI, queues them in a first-word-fall-through FIFO for a host-side reader, and counts overflow drops. On an end-of-test request it runs a drain/ended handshake. It sits between the CPU OCI block and the JTAG/debug readout path.

## Interface
- DCT_W, 30, width of dct_buffer
- CNT_W, 4, width of dct_count
- DEPTH, 16, FIFO entries; power of two, minimum 2
- OVF_W, 8, width of saturating overflow counter
- TS_W, 16, timestamp width (used only with the timestamp feature)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dct_valid  in  1  frame strobe
- dct_buffer  in  DCT_W  frame payload
- dct_count  in  CNT_W  valid slots in frame; 0 = empty frame
- test_ending  in  1  single-cycle pulse requesting drain
- out_valid  out  1  head entry available
- out_ready  in  1  reader pops head when out_valid && out_ready
- out_buffer  out  DCT_W  head payload
- out_count  out  CNT_W  head count
- out_ts  out  TS_W  head timestamp; 0 when feature absent
- overflow  out  1  sticky: at least one frame dropped
- ovf_count  out  OVF_W  dropped frames, saturating
- test_has_ended  out  1  drain complete

## Operation
- States: CAPTURE (reset state), DRAIN, ENDED.
- Push condition: state==CAPTURE && dct_valid && dct_count!=0 && (!full || pop this cycle).
- A frame with dct_count==0 is discarded silently. It does not count as overflow.
- Drop: state==CAPTURE && dct_valid && dct_count!=0 && full && !pop. On a drop, overflow is set and ovf_count increments, saturating at all-ones.
- Frames arriving in DRAIN or ENDED are ignored. They do not count as overflow.
- CAPTURE→DRAIN on test_ending.
- DRAIN→ENDED when the FIFO is empty, including an empty reached through a pop in the same cycle.
- ENDED is terminal until reset.
- test_ending pulses while in DRAIN or ENDED have no effect.
- A test_ending pulse arriving in the same cycle as a push: the push is accepted, then the transition to DRAIN takes place.
- The reader may keep popping in every state.
- Reset mid-operation clears FIFO pointers, state, flags and counters immediately. Stored payload RAM contents need not be cleared.

## Timing
- Reset values: out_valid 0, out_buffer/out_count/out_ts 0, overflow 0, ovf_count 0, test_has_ended 0, state CAPTURE.
- Write-to-read latency: a frame pushed at edge N gives out_valid=1 with its data after edge N.
- The head is registered and stable while out_valid && !out_ready.
- Throughput: one push and one pop per cycle, simultaneously, including when the FIFO is full or empty. A push into an empty FIFO while the reader is ready cannot pop that frame in the same cycle.
- test_has_ended asserts the cycle after entry into ENDED and stays high until reset.
- Minimum test_ending-to-test_has_ended latency, when the FIFO is empty: 2 cycles.
- Occupancy uses pointers of clog2(DEPTH)+1 bits. Full and empty are decoded from the MSB comparison. Wrap-around is modulo 2·DEPTH.

## Configuration
- Macro OCI_DCT_TIMESTAMP_EN.
- Defined: a TS_W-bit free-running counter, reset to 0 and wrapping, is stored with each pushed frame and is presented on out_ts. The timestamp is the counter value in the push cycle.
- Undefined: no counter and no timestamp storage are built, and out_ts is tied to 0.

## Structure
- Shared package bemicro_cv_nios_cpu_oci_dct_pkg holds:
  - the state enum (CAPTURE, DRAIN, ENDED);
  - default parameter constants;
  - a packed entry struct {ts, count, buffer}.
- One sub-module, bemicro_cv_nios_cpu_oci_dct_fifo. It is a generic FWFT synchronous FIFO, parametrised by width and depth, with push/pop/full/empty.
- The top level owns the state machine, the drop logic and the timestamp counter.

## Test plan
- Capture three frames with dct_count=3 (payloads 0x1, 0x2, 0x3) while out_ready=0, then set out_ready=1 → the frames pop in the order 0x1, 0x2, 0x3, each with out_count=3, and out_valid falls after the third pop.
- Present a frame with dct_count=0 and payload 0x3FFFFFFF → out_valid stays 0, overflow stays 0 and ovf_count stays 0.
- Fill 16 entries, then push 300 further frames with out_ready=0 → overflow=1, ovf_count=255, and the FIFO still holds the first 16 frames.
- With the FIFO full, push and pop in the same cycle → the push is accepted, no drop is recorded, and the FIFO remains full.
- Load 4 frames, then pulse test_ending and pop one frame per cycle → test_has_ended rises the cycle after the fourth pop, and a frame presented during DRAIN never appears at the output.
- Assert reset while in DRAIN with 5 entries queued → out_valid=0, test_has_ended=0 and ovf_count=0 the cycle after assertion, and the state returns to CAPTURE. With OCI_DCT_TIMESTAMP_EN defined, the first frame pushed on the second cycle after reset release carries out_ts=1.
